// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: framed command decoder behind the UART receiver.
// Frame: AA 55 CMD LEN payload[LEN] CSUM, CSUM = CMD + LEN + sum(payload) mod 256.
// A good frame updates the command outputs and pulses cmd_valid_o; a bad,
// oversize or stalled frame pulses cmd_err_o with a reason code.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN     = 8,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        rx_done_i,
  input  logic [7:0]  rx_data_i,
  output logic        cmd_valid_o,
  output logic [7:0]  cmd_id_o,
  output logic [3:0]  cmd_len_o,
  output logic [63:0] cmd_payload_o,
  output logic        cmd_err_o,
  output logic [1:0]  cmd_err_code_o
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t      state_reg, state_next;
  logic [7:0]  sum_reg, sum_next;
  logic [2:0]  idx_reg, idx_next;
  logic [3:0]  len_reg, len_next;
  logic [7:0]  id_reg, id_next;
  logic [63:0] pay_reg, pay_next;
  logic [19:0] tmo_reg, tmo_next;

  logic        valid_reg, valid_next;
  logic        err_reg, err_next;
  logic [1:0]  code_reg, code_next;
  logic [7:0]  out_id_reg, out_id_next;
  logic [3:0]  out_len_reg, out_len_next;
  logic [63:0] out_pay_reg, out_pay_next;

  // Payload lane controls produced by the FSM and consumed by the lane logic.
  logic        pay_clr;
  logic        pay_we;

  // A byte arriving on the terminal count takes priority over the timeout.
  logic        timeout_hit;
  assign timeout_hit = (state_reg != S_HDR0) && (tmo_reg == TIMEOUT_CYC) && !rx_done_i;

  // Working payload: each byte lane is either cleared at CMD, loaded when the
  // index selects it in PAY, or held.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign pay_next[8*gi +: 8] = pay_clr ? 8'h00 :
                                   (pay_we && (idx_reg == 3'(gi))) ? rx_data_i :
                                   pay_reg[8*gi +: 8];
    end
  endgenerate

  // Next-state and datapath decode for the frame FSM and the byte-gap timer.
  always_comb begin
    state_next   = state_reg;
    sum_next     = sum_reg;
    idx_next     = idx_reg;
    len_next     = len_reg;
    id_next      = id_reg;
    pay_clr      = 1'b0;
    pay_we       = 1'b0;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    code_next    = code_reg;
    out_id_next  = out_id_reg;
    out_len_next = out_len_reg;
    out_pay_next = out_pay_reg;

    // Timer idles at zero while hunting for a header and restarts on every byte.
    if (rx_done_i || (state_reg == S_HDR0) || timeout_hit) begin
      tmo_next = 20'd0;
    end else begin
      tmo_next = tmo_reg + 20'd1;
    end

    if (rx_done_i) begin
      case (state_reg)
        S_HDR0: begin
          if (rx_data_i == 8'hAA) state_next = S_HDR1;
        end
        S_HDR1: begin
          if (rx_data_i == 8'h55)      state_next = S_CMD;
          else if (rx_data_i == 8'hAA) state_next = S_HDR1;
          else                         state_next = S_HDR0;
        end
        S_CMD: begin
          id_next    = rx_data_i;
          sum_next   = rx_data_i;
          pay_clr    = 1'b1;
          state_next = S_LEN;
        end
        S_LEN: begin
          sum_next = sum_reg + rx_data_i;
          if (rx_data_i > MAX_LEN_B) begin
            err_next   = 1'b1;
            code_next  = ERR_LEN;
            state_next = S_HDR0;
          end else begin
            len_next = rx_data_i[3:0];
            idx_next = 3'd0;
            if (rx_data_i == 8'h00) state_next = S_CSUM;
            else                    state_next = S_PAY;
          end
        end
        S_PAY: begin
          pay_we   = 1'b1;
          sum_next = sum_reg + rx_data_i;
          idx_next = idx_reg + 3'd1;
          if ({1'b0, idx_reg} == (len_reg - 4'd1)) state_next = S_CSUM;
        end
        S_CSUM: begin
          if (rx_data_i == sum_reg) begin
            valid_next   = 1'b1;
            out_id_next  = id_reg;
            out_len_next = len_reg;
            out_pay_next = pay_reg;
          end else begin
            err_next  = 1'b1;
            code_next = ERR_CSUM;
          end
          state_next = S_HDR0;
        end
        default: state_next = S_HDR0;
      endcase
    end else if (timeout_hit) begin
      err_next   = 1'b1;
      code_next  = ERR_TIMEOUT;
      state_next = S_HDR0;
    end
  end

  // Register file for the FSM, working frame and registered outputs.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg   <= S_HDR0;
      sum_reg     <= 8'd0;
      idx_reg     <= 3'd0;
      len_reg     <= 4'd0;
      id_reg      <= 8'd0;
      pay_reg     <= 64'd0;
      tmo_reg     <= 20'd0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      code_reg    <= 2'd0;
      out_id_reg  <= 8'd0;
      out_len_reg <= 4'd0;
      out_pay_reg <= 64'd0;
    end else begin
      state_reg   <= state_next;
      sum_reg     <= sum_next;
      idx_reg     <= idx_next;
      len_reg     <= len_next;
      id_reg      <= id_next;
      pay_reg     <= pay_next;
      tmo_reg     <= tmo_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      code_reg    <= code_next;
      out_id_reg  <= out_id_next;
      out_len_reg <= out_len_next;
      out_pay_reg <= out_pay_next;
    end
  end

  assign cmd_valid_o    = valid_reg;
  assign cmd_err_o      = err_reg;
  assign cmd_err_code_o = code_reg;
  assign cmd_id_o       = out_id_reg;
  assign cmd_len_o      = out_len_reg;
  assign cmd_payload_o  = out_pay_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: expected frame results are queued as
// bytes are sent and retired by a monitor when the strobes appear.
module tb_uart_cmd_parser;

  logic        clk;
  logic        irst;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        cmd_valid_o;
  logic [7:0]  cmd_id_o;
  logic [3:0]  cmd_len_o;
  logic [63:0] cmd_payload_o;
  logic        cmd_err_o;
  logic [1:0]  cmd_err_code_o;

  uart_cmd_parser #(
    .MAX_LEN     (8),
    .TIMEOUT_CYC (20'd100)
  ) dut (
    .iclk           (clk),
    .irst           (irst),
    .rx_done_i      (rx_done),
    .rx_data_i      (rx_data),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_id_o       (cmd_id_o),
    .cmd_len_o      (cmd_len_o),
    .cmd_payload_o  (cmd_payload_o),
    .cmd_err_o      (cmd_err_o),
    .cmd_err_code_o (cmd_err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  id;
    logic [3:0]  len;
    logic [63:0] payload;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  tx_q[$];
  int          tests = 0;
  int          fails = 0;

  // Model of the last good frame, i.e. what the data outputs must hold.
  logic [7:0]  mdl_id  = 8'd0;
  logic [3:0]  mdl_len = 4'd0;
  logic [63:0] mdl_pay = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_valid(input logic [7:0] id, input logic [3:0] len, input logic [63:0] pay);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.id = id; e.len = len; e.payload = pay;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.id = 8'd0; e.len = 4'd0; e.payload = 64'd0;
    exp_q.push_back(e);
  endtask

  // Sends tx_q; b2b keeps rx_done high every cycle, otherwise one idle cycle
  // between bytes. Returns on the negedge after the last byte was sampled.
  task automatic flush_tx(input bit b2b);
    while (tx_q.size() > 0) begin
      @(negedge clk);
      rx_done = 1'b1;
      rx_data = tx_q.pop_front();
      if (!b2b) begin
        @(negedge clk);
        rx_done = 1'b0;
      end
    end
    if (b2b) begin
      @(negedge clk);
      rx_done = 1'b0;
    end
  endtask

  // Retire one queued expectation for every strobe seen.
  always @(negedge clk) begin
    if (cmd_valid_o || cmd_err_o) begin
      exp_t e;
      chk("strobe_exclusive", 64'(cmd_valid_o & cmd_err_o), 64'd0);
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_strobe: observed valid=%0b err=%0b code=%0d expected no strobe",
               cmd_valid_o, cmd_err_o, cmd_err_code_o);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("strobe_kind_err", 64'(cmd_err_o), 64'(e.is_err));
        if (e.is_err) begin
          chk("err_code", 64'(cmd_err_code_o), 64'(e.code));
          chk("hold_id", 64'(cmd_id_o), 64'(mdl_id));
          chk("hold_len", 64'(cmd_len_o), 64'(mdl_len));
          chk("hold_payload", cmd_payload_o, mdl_pay);
        end else begin
          chk("cmd_id", 64'(cmd_id_o), 64'(e.id));
          chk("cmd_len", 64'(cmd_len_o), 64'(e.len));
          chk("cmd_payload", cmd_payload_o, e.payload);
          mdl_id  = e.id;
          mdl_len = e.len;
          mdl_pay = e.payload;
        end
      end
    end
  end

  initial begin
    int cyc;
    irst    = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(cmd_valid_o), 64'd0);
    chk("rst_err", 64'(cmd_err_o), 64'd0);
    chk("rst_code", 64'(cmd_err_code_o), 64'd0);
    chk("rst_id", 64'(cmd_id_o), 64'd0);
    chk("rst_len", 64'(cmd_len_o), 64'd0);
    chk("rst_payload", cmd_payload_o, 64'd0);
    irst = 1'b0;

    // Basic good frame; valid must be up the cycle after CSUM.
    push_valid(8'h01, 4'd2, 64'h2010);
    tx_q = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    flush_tx(1'b0);
    chk("f1_valid_timing", 64'(cmd_valid_o), 64'd1);
    $display("[TB] frame AA 55 01 02 10 20 33 -> id=%h len=%0d pay=%h", cmd_id_o, cmd_len_o, cmd_payload_o);

    // Same frame, bad checksum.
    push_err(2'd1);
    tx_q = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    flush_tx(1'b0);
    chk("csum_err_timing", 64'(cmd_err_o), 64'd1);
    $display("[TB] frame bad csum -> err=%0b code=%0d", cmd_err_o, cmd_err_code_o);

    // Oversize LEN, error the cycle after the LEN byte.
    push_err(2'd2);
    tx_q = '{8'hAA, 8'h55, 8'h05, 8'h09};
    flush_tx(1'b0);
    chk("len_err_timing", 64'(cmd_err_o), 64'd1);
    chk("len_err_code", 64'(cmd_err_code_o), 64'd2);
    $display("[TB] frame LEN=9 -> err=%0b code=%0d", cmd_err_o, cmd_err_code_o);

    // Zero-length frame.
    push_valid(8'h02, 4'd0, 64'd0);
    tx_q = '{8'hAA, 8'h55, 8'h02, 8'h00, 8'h02};
    flush_tx(1'b0);
    chk("len0_valid_timing", 64'(cmd_valid_o), 64'd1);
    $display("[TB] frame LEN=0 -> id=%h len=%0d", cmd_id_o, cmd_len_o);

    // Resync on repeated AA, checksum wraps.
    push_valid(8'h03, 4'd1, 64'hFF);
    tx_q = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h03, 8'h01, 8'hFF, 8'h03};
    flush_tx(1'b0);
    chk("resync_valid_timing", 64'(cmd_valid_o), 64'd1);
    $display("[TB] resync frame -> id=%h len=%0d pay=%h", cmd_id_o, cmd_len_o, cmd_payload_o);

    // Stall after CMD: timeout 100 cycles after last byte plus register stage.
    push_err(2'd3);
    tx_q = '{8'hAA, 8'h55, 8'h07};
    flush_tx(1'b0);
    cyc = 0;
    while (cmd_err_o !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_latency", 64'(cyc), 64'd101);
    chk("timeout_code", 64'(cmd_err_code_o), 64'd3);
    $display("[TB] stalled frame -> err after %0d cycles code=%0d", cyc, cmd_err_code_o);

    // Same stall, but a byte lands exactly on the terminal count.
    push_valid(8'h07, 4'd0, 64'd0);
    tx_q = '{8'hAA, 8'h55, 8'h07};
    flush_tx(1'b0);
    repeat (99) @(negedge clk);
    tx_q = '{8'h00};
    flush_tx(1'b0);
    chk("terminal_byte_no_err", 64'(cmd_err_o), 64'd0);
    tx_q = '{8'h07};
    flush_tx(1'b0);
    chk("terminal_valid_timing", 64'(cmd_valid_o), 64'd1);
    $display("[TB] byte on terminal count -> valid=%0b id=%h", cmd_valid_o, cmd_id_o);

    // Back-to-back frames, second at maximum length.
    push_valid(8'h04, 4'd3, 64'h030201);
    push_valid(8'h08, 4'd8, 64'h0807060504030201);
    tx_q = '{8'hAA, 8'h55, 8'h04, 8'h03, 8'h01, 8'h02, 8'h03, 8'h0D,
             8'hAA, 8'h55, 8'h08, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08, 8'h34};
    flush_tx(1'b1);
    chk("b2b_valid_timing", 64'(cmd_valid_o), 64'd1);
    $display("[TB] back-to-back frames -> last id=%h len=%0d pay=%h", cmd_id_o, cmd_len_o, cmd_payload_o);

    // Reset in the middle of a frame.
    tx_q = '{8'hAA, 8'h55, 8'h01, 8'h04, 8'h11};
    flush_tx(1'b0);
    irst = 1'b1;
    @(negedge clk);
    irst = 1'b0;
    mdl_id  = 8'd0;
    mdl_len = 4'd0;
    mdl_pay = 64'd0;
    chk("midrst_valid", 64'(cmd_valid_o), 64'd0);
    chk("midrst_err", 64'(cmd_err_o), 64'd0);
    chk("midrst_code", 64'(cmd_err_code_o), 64'd0);
    chk("midrst_id", 64'(cmd_id_o), 64'd0);
    chk("midrst_len", 64'(cmd_len_o), 64'd0);
    chk("midrst_payload", cmd_payload_o, 64'd0);
    $display("[TB] mid-frame reset -> id=%h len=%0d code=%0d", cmd_id_o, cmd_len_o, cmd_err_code_o);

    push_valid(8'h01, 4'd2, 64'h2010);
    tx_q = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    flush_tx(1'b0);
    chk("post_rst_valid_timing", 64'(cmd_valid_o), 64'd1);
    $display("[TB] frame after reset -> id=%h len=%0d pay=%h", cmd_id_o, cmd_len_o, cmd_payload_o);

    repeat (5) @(negedge clk);
    chk("pending_expectations", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command-frame parser that sits directly downstream of the UART receive path. It consumes the `uart_rx_done` strobe and `uart_rx_data_o` byte from that path, and resynchronises on a two-byte header. It checks length and an 8-bit additive checksum, then presents a decoded command (ID, length, up to 8 payload bytes) with a one-cycle valid strobe. Malformed, oversize or stalled frames are dropped with a one-cycle error strobe and an error code.

## Interface
- `MAX_LEN`, 8: maximum payload bytes accepted (1..8).
- `TIMEOUT_CYC`, 20'd1000000: idle cycles allowed between bytes inside a frame before abort (10 ms at 100 MHz).
- `iclk`  in  1  system clock, single clock domain.
- `irst`  in  1  synchronous, active-high reset.
- `rx_done_i`  in  1  one-cycle strobe: new byte on `rx_data_i`.
- `rx_data_i`  in  8  received byte; valid when `rx_done_i`=1.
- `cmd_valid_o`  out  1  one-cycle strobe: good frame decoded.
- `cmd_id_o`  out  8  command ID of last good frame.
- `cmd_len_o`  out  4  payload length of last good frame.
- `cmd_payload_o`  out  64  payload of last good frame; byte k in bits [8k+7:8k], unused bytes zero.
- `cmd_err_o`  out  1  one-cycle strobe: frame dropped.
- `cmd_err_code_o`  out  2  reason for last drop: 1 checksum, 2 length, 3 timeout; 0 after reset.

## Operation
- Frame format: 0xAA, 0x55, CMD, LEN, LEN payload bytes, CSUM. CSUM = (CMD + LEN + sum of payload) mod 256.
- FSM states: HDR0, HDR1, CMD, LEN, PAY, CSUM. It advances only on `rx_done_i`=1, except on timeout.
- HDR0: byte 0xAA -> HDR1; any other byte -> stay.
- HDR1: 0x55 -> CMD; 0xAA -> stay in HDR1 (resync); other -> HDR0.
- CMD: latch ID into working register, set running sum = byte, clear working payload to 0 -> LEN.
- LEN: if byte > MAX_LEN -> error code 2, -> HDR0. If byte = 0 -> CSUM. Otherwise latch length, byte index = 0 -> PAY. In every case, add byte to sum.
- PAY: write byte at working payload[8·index +: 8], add to sum, increment index. When index reaches length-1 on this byte -> CSUM.
- CSUM: if byte == sum, copy working ID/len/payload to outputs and pulse `cmd_valid_o`; else error code 2'd1. Either way -> HDR0.
- Outputs `cmd_id_o`/`cmd_len_o`/`cmd_payload_o` change only on a good frame and hold otherwise. `cmd_err_code_o` holds until the next error.
- Sum is 8 bits, wraps modulo 256. Index is 3 bits and is compared against a 4-bit length.
- Timeout counter (20 bits): cleared on every `rx_done_i`, and held at 0 in HDR0. Otherwise it increments. When it equals TIMEOUT_CYC: pulse error code 3, -> HDR0, clear counter.
- `rx_done_i` in the same cycle as the timeout terminal count: the byte wins. It is processed normally, the counter clears, and no error is raised.
- Back-to-back frames are accepted with no gap. The byte after CSUM is evaluated in HDR0.

## Timing
- All outputs are registered.
- `cmd_valid_o` asserts the cycle after the `rx_done_i` carrying CSUM. Data outputs are updated in that same cycle.
- `cmd_err_o` asserts the cycle after the offending `rx_done_i` (codes 1, 2), or the cycle after the counter reaches TIMEOUT_CYC (code 3).
- `cmd_valid_o` and `cmd_err_o` are never high together and never high for more than one cycle.
- Reset values: FSM HDR0, `cmd_valid_o`=0, `cmd_err_o`=0, `cmd_err_code_o`=0, `cmd_id_o`=0, `cmd_len_o`=0, `cmd_payload_o`=0, sum/index/counter=0.
- `irst` mid-frame: the partial frame is discarded with no error strobe, and all outputs return to reset values on the next edge.
- Throughput: accepts one byte per cycle. No backpressure, since the upstream byte rate is far slower.

## Test plan
- Good frame AA 55 01 02 10 20 33 -> one `cmd_valid_o` pulse; `cmd_id_o`=0x01, `cmd_len_o`=2, `cmd_payload_o`=0x0000_0000_0000_2010; no `cmd_err_o`.
- Same frame with CSUM 0x34 -> `cmd_err_o` pulse, code 1; outputs keep previous values.
- AA 55 05 09 (LEN=9 > 8) -> `cmd_err_o` pulse, code 2, the cycle after the LEN byte. A following good frame AA 55 02 00 02 then decodes with id 0x02, len 0, payload 0.
- Resync: 12 AA AA 55 03 01 FF 03 -> valid; id 0x03, len 1, payload 0xFF. The sum 03+01+FF wraps to 0x03.
- With TIMEOUT_CYC=100: send AA 55 07, then idle. `cmd_err_o` code 3 exactly 100 cycles after the last `rx_done_i`, plus the registered cycle. A repeat run with a byte landing on cycle 100 produces no error.
- Assert `irst` for one cycle after AA 55 01 04 11 -> all outputs 0. The subsequent good frame AA 55 01 02 10 20 33 decodes correctly.
